// File: rtl/main_memory.sv
// Byte-organised, big-endian word memory behind the data cache.
// Serves one fill or write-back at a time with a fixed, per-operation latency.
module main_memory #(
  parameter int ADDR_BITS     = 16,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_write_en,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_data_out,
  output logic        mem_ready,
  output logic        mem_done
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]           state_reg, state_next;
  logic [3:0]           count_reg, count_next;
  logic [ADDR_BITS-3:0] word_reg, word_next;
  logic [31:0]          wdata_reg, wdata_next;
  logic                 op_write_reg, op_write_next;
  logic                 ready_reg, ready_next;
  logic                 done_reg, done_next;
  logic [31:0]          data_out_reg, data_out_next;
  logic                 commit;
  logic [31:0]          read_word;

  // Upper address bits wrap and the byte offset is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_address[31:ADDR_BITS], mem_address[1:0]};

  logic [7:0] mem_bytes [0:DEPTH-1];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign read_word[31-8*gi -: 8] = mem_bytes[{word_reg, 2'(gi)}];
    end
  endgenerate

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        mem_bytes[{word_reg, 2'(b)}] <= wdata_reg[31-8*b -: 8];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    word_next     = word_reg;
    wdata_next    = wdata_reg;
    op_write_next = op_write_reg;
    ready_next    = ready_reg;
    done_next     = 1'b0;
    data_out_next = data_out_reg;
    commit        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (mem_req) begin
          word_next     = mem_address[ADDR_BITS-1:2];
          wdata_next    = mem_data_in;
          op_write_next = mem_write_en;
          count_next    = mem_write_en ? 4'(WRITE_LATENCY - 1) : 4'(READ_LATENCY - 1);
          ready_next    = 1'b0;
          state_next    = mem_write_en ? ST_WRITE : ST_READ;
        end
      end
      ST_READ, ST_WRITE: begin
        if (count_reg == 4'd0) begin
          done_next  = 1'b1;
          state_next = ST_DONE;
          if (op_write_reg) commit = 1'b1;
          else              data_out_next = read_word;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      default: begin
        ready_next = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      count_reg    <= 4'd0;
      word_reg     <= '0;
      wdata_reg    <= 32'd0;
      op_write_reg <= 1'b0;
      ready_reg    <= 1'b1;
      done_reg     <= 1'b0;
      data_out_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      word_reg     <= word_next;
      wdata_reg    <= wdata_next;
      op_write_reg <= op_write_next;
      ready_reg    <= ready_next;
      done_reg     <= done_next;
      data_out_reg <= data_out_next;
    end
  end

  assign mem_data_out = data_out_reg;
  assign mem_ready    = ready_reg;
  assign mem_done     = done_reg;

endmodule

// File: tb/tb_main_memory.sv
// Randomised bench for main_memory against a byte-level reference model.
module tb_main_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_write_en, mem_ready, mem_done;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        b_req, b_we, b_ready, b_done;
  logic [31:0] b_addr, b_din, b_dout;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  model_mem [int];
  logic [31:0] exp_dout;

  main_memory #(.ADDR_BITS(16), .READ_LATENCY(4), .WRITE_LATENCY(4)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_write_en(mem_write_en),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_ready(mem_ready), .mem_done(mem_done)
  );

  main_memory #(.ADDR_BITS(16), .READ_LATENCY(1), .WRITE_LATENCY(9)) dut_b (
    .clk(clk), .reset(reset), .mem_req(b_req), .mem_write_en(b_we),
    .mem_address(b_addr), .mem_data_in(b_din),
    .mem_data_out(b_dout), .mem_ready(b_ready), .mem_done(b_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int word_key(input logic [31:0] addr);
    return int'({16'd0, addr[15:2], 2'b00});
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    logic [31:0] w;
    int k;
    k = word_key(addr);
    for (int b = 0; b < 4; b++) w[31-8*b -: 8] = model_mem.exists(k + b) ? model_mem[k + b] : 8'h00;
    return w;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
    int k;
    k = word_key(addr);
    for (int b = 0; b < 4; b++) model_mem[k + b] = data[31-8*b -: 8];
  endtask

  // One access on the main instance; inject>0 pulses a conflicting write at that busy cycle.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] data,
                        input int inject);
    int cyc;
    logic [31:0] exp;
    exp = model_read(addr);
    @(negedge clk);
    check("ready_before_req", 32'(mem_ready), 32'd1);
    mem_req = 1'b1; mem_write_en = we; mem_address = addr; mem_data_in = data;
    @(posedge clk); #1;
    mem_req = 1'b0;
    mem_address = $urandom; mem_data_in = $urandom; mem_write_en = $urandom_range(0, 1);
    check("ready_busy", 32'(mem_ready), 32'd0);
    cyc = 0;
    while (!mem_done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == inject) begin
        mem_req = 1'b1; mem_write_en = 1'b1; mem_address = addr; mem_data_in = 32'd0;
      end else begin
        mem_req = 1'b0;
      end
    end
    mem_req = 1'b0;
    check(we ? "write_latency" : "read_latency", 32'(cyc), 32'd4);
    check("ready_in_done", 32'(mem_ready), 32'd0);
    if (we) model_write(addr, data);
    else    exp_dout = exp;
    check(we ? "dout_after_write" : "read_data", mem_data_out, exp_dout);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(mem_done), 32'd0);
    check("ready_return", 32'(mem_ready), 32'd1);
    $display("[TB] %s addr=%08h data=%08h dout=%08h lat=%0d", we ? "WR" : "RD", addr, data, mem_data_out, cyc);
  endtask

  initial begin
    logic [31:0] pool [8];
    logic [31:0] a, pre;
    int cyc;
    pool = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h1000, 32'hFFFC, 32'h8000, 32'h0};
    reset = 1'b0; mem_req = 1'b0; mem_write_en = 1'b0; mem_address = 0; mem_data_in = 0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 0; b_din = 0;
    exp_dout = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(mem_ready), 32'd1);
    check("rst_done", 32'(mem_done), 32'd0);
    check("rst_dout", mem_data_out, 32'd0);
    @(negedge clk); reset = 1'b1;

    access(1'b1, 32'h100, 32'hDEADBEEF, -1);
    access(1'b0, 32'h100, 32'h0, -1);
    check("plan_read_deadbeef", mem_data_out, 32'hDEADBEEF);

    access(1'b1, 32'h200, 32'h11223344, -1);
    check("byte_200", 32'(dut.mem_bytes[16'h200]), 32'h11);
    check("byte_201", 32'(dut.mem_bytes[16'h201]), 32'h22);
    check("byte_202", 32'(dut.mem_bytes[16'h202]), 32'h33);
    check("byte_203", 32'(dut.mem_bytes[16'h203]), 32'h44);

    access(1'b0, 32'h100, 32'h0, 2);
    check("busy_ignored_read", mem_data_out, 32'hDEADBEEF);
    access(1'b0, 32'h100, 32'h0, -1);
    check("busy_ignored_loc", mem_data_out, 32'hDEADBEEF);

    access(1'b1, 32'h0001_0402, 32'hA5A5A5A5, -1);
    access(1'b0, 32'h0000_0400, 32'h0, -1);
    check("wrap_misalign", mem_data_out, 32'hA5A5A5A5);

    // Reset in the middle of a write.
    access(1'b1, 32'h300, 32'h01020304, -1);
    pre = model_read(32'h300);
    @(negedge clk);
    mem_req = 1'b1; mem_write_en = 1'b1; mem_address = 32'h300; mem_data_in = 32'hCAFEF00D;
    @(posedge clk); #1; mem_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    check("midrst_ready", 32'(mem_ready), 32'd1);
    check("midrst_done", 32'(mem_done), 32'd0);
    check("midrst_dout", mem_data_out, 32'd0);
    exp_dout = 32'd0;
    @(negedge clk); reset = 1'b1;
    access(1'b0, 32'h300, 32'h0, -1);
    check("midrst_unchanged", mem_data_out, pre);

    foreach (pool[i]) access(1'b1, pool[i], $urandom, -1);
    for (int n = 0; n < 60; n++) begin
      a = pool[$urandom_range(0, 7)];
      a = {16'($urandom), a[15:2], 2'($urandom_range(0, 3))};
      access(1'($urandom_range(0, 1)), a, $urandom, -1);
    end

    // Second instance: asymmetric latencies.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      b_we = (k == 0); b_req = 1'b1; b_addr = 32'h40; b_din = 32'h0F1E2D3C;
      @(posedge clk); #1; b_req = 1'b0; b_din = 32'd0;
      cyc = 0;
      while (!b_done && cyc < 40) begin
        @(posedge clk); #1; cyc++;
      end
      check(k == 0 ? "b_write_latency" : "b_read_latency", 32'(cyc), k == 0 ? 32'd9 : 32'd1);
      check("b_ready_in_done", 32'(b_ready), 32'd0);
      @(posedge clk); #1;
      check("b_ready_return", 32'(b_ready), 32'd1);
      check("b_done_clear", 32'(b_done), 32'd0);
      $display("[TB] B %s lat=%0d dout=%08h", k == 0 ? "WR" : "RD", cyc, b_dout);
    end
    check("b_read_data", b_dout, 32'h0F1E2D3C);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
